wts_mix_scheduler: RTL and testbench

Time-division mixing sequencer for the wave-table sound core. Once per output-sample frame it walks 12 voice slots (6 channels x 2 sound blocks). For each slot it fetches a signed sample from the channel units over a req/ack handshake, then weights the sample by the slot's 4-bit volume and routes it by the slot's 2-bit enable. It accumulates left and right sums, and at frame end it saturates them into offset-binary 12-bit DAC words. It sits between the per-channel wave generators and the DAC/output stage, and owns all mixing timing.

---
 rtl/wts_mix_scheduler.sv | 171 +++++++++++++++++
 tb/tb_wts_mix_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_mix_scheduler.sv
// wts_mix_scheduler: per-frame 12-slot sample fetch, volume weighting, L/R mix and offset-binary DAC output.
// Optional ack timeout: define WTS_MIX_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module wts_mix_scheduler #(
    parameter int NUM_SLOTS      = 12,
    parameter int FRAME_CYCLES   = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        nreset,
    input  logic        clk,
    output logic [3:0]  slot_sel,
    output logic        sample_req,
    input  logic        sample_ack,
    input  logic [7:0]  sample_data,
    input  logic [3:0]  slot_volume,
    input  logic [1:0]  slot_enable,
    input  logic        clr_flags,
    output logic [11:0] left_out,
    output logic [11:0] right_out,
    output logic        out_valid,
    output logic        overrun,
    output logic        timeout
);

    localparam int FCW = $clog2(FRAME_CYCLES);

    if (FRAME_CYCLES < 2*NUM_SLOTS+2 || TIMEOUT_CYCLES < 1 || NUM_SLOTS > 16) begin : g_cfg_check
        $error("wts_mix_scheduler: invalid parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [FCW-1:0]     frame_q;
    logic [3:0]         slot_q;
    logic [7:0]         sample_q;
    logic signed [15:0] acc_l_q, acc_r_q;
    logic signed [15:0] acc_l_d, acc_r_d;
    logic signed [11:0] prod;
    logic signed [15:0] prod_ext;
    logic               req_q, valid_q, overrun_q;
    logic [11:0]        left_q, right_q;
    logic               frame_tick;
    logic               last_slot;

    assign frame_tick = (frame_q == FCW'(FRAME_CYCLES-1));
    assign last_slot  = (slot_q == 4'(NUM_SLOTS-1));

    // Worst case |sample*volume| is 1920, so a 12-bit signed product is exact.
    assign prod     = $signed({{4{sample_q[7]}}, sample_q}) * $signed({8'b0, slot_volume});
    assign prod_ext = {{4{prod[11]}}, prod};
    assign acc_l_d  = acc_l_q + (slot_enable[0] ? prod_ext : 16'sd0);
    assign acc_r_d  = acc_r_q + (slot_enable[1] ? prod_ext : 16'sd0);

    function automatic logic [11:0] to_dac(input logic signed [15:0] acc);
        logic signed [15:0] v;
        v = acc >>> 2;
        if (v > 16'sd2047)
            return 12'hFFF;
        else if (v < -16'sd2048)
            return 12'h000;
        else
            return {~v[11], v[10:0]};
    endfunction

`ifdef WTS_MIX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES+1);
    logic [WW-1:0] wait_q;
    logic          timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            frame_q   <= '0;
            slot_q    <= 4'd0;
            sample_q  <= 8'd0;
            acc_l_q   <= 16'sd0;
            acc_r_q   <= 16'sd0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            left_q    <= 12'h800;
            right_q   <= 12'h800;
            overrun_q <= 1'b0;
`ifdef WTS_MIX_TIMEOUT_EN
            wait_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            frame_q   <= frame_tick ? '0 : frame_q + 1'b1;
            // A set in the same cycle as clr_flags leaves the flag set.
            overrun_q <= (overrun_q & ~clr_flags) | (frame_tick && (state_q != S_IDLE));
`ifdef WTS_MIX_TIMEOUT_EN
            timeout_q <= timeout_q & ~clr_flags;
`endif
            case (state_q)
                S_IDLE: begin
                    if (frame_tick) begin
                        acc_l_q <= 16'sd0;
                        acc_r_q <= 16'sd0;
                        slot_q  <= 4'd0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`ifdef WTS_MIX_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (sample_ack) begin
                        sample_q <= sample_data;
                        req_q    <= 1'b0;
                        state_q  <= S_ACC;
                    end
`ifdef WTS_MIX_TIMEOUT_EN
                    else if (wait_q == WW'(TIMEOUT_CYCLES-1)) begin
                        sample_q  <= 8'd0;
                        timeout_q <= 1'b1;
                        req_q     <= 1'b0;
                        state_q   <= S_ACC;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
`endif
                end
                S_ACC: begin
                    acc_l_q <= acc_l_d;
                    acc_r_q <= acc_r_d;
                    // Load the DAC words on the last slot so they are valid with out_valid.
                    if (last_slot) begin
                        left_q  <= to_dac(acc_l_d);
                        right_q <= to_dac(acc_r_d);
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        slot_q  <= slot_q + 4'd1;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
`ifdef WTS_MIX_TIMEOUT_EN
                        wait_q  <= '0;
`endif
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign slot_sel   = slot_q;
    assign sample_req = req_q;
    assign left_out   = left_q;
    assign right_out  = right_q;
    assign out_valid  = valid_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_wts_mix_scheduler.sv
// tb_wts_mix_scheduler: scoreboard bench for wts_mix_scheduler; a behavioural channel unit answers sample requests.
`default_nettype none

module tb_wts_mix_scheduler;

`ifdef WTS_MIX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO_CYC = 16;

    logic        clk = 1'b0;
    logic        nreset;
    logic [3:0]  slot_sel;
    logic        sample_req;
    logic        sample_ack;
    logic [7:0]  sample_data;
    logic [3:0]  slot_volume;
    logic [1:0]  slot_enable;
    logic        clr_flags;
    logic [11:0] left_out, right_out;
    logic        out_valid, overrun, timeout;

    byte         s_tab [12];
    int          v_tab [12];
    logic [1:0]  e_tab [12];
    int          d_tab [12];
    logic        spur;
    int          ack_wait;

    logic [23:0] sb [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    wts_mix_scheduler dut (
        .nreset      (nreset),
        .clk         (clk),
        .slot_sel    (slot_sel),
        .sample_req  (sample_req),
        .sample_ack  (sample_ack),
        .sample_data (sample_data),
        .slot_volume (slot_volume),
        .slot_enable (slot_enable),
        .clr_flags   (clr_flags),
        .left_out    (left_out),
        .right_out   (right_out),
        .out_valid   (out_valid),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    assign slot_volume = 4'(v_tab[slot_sel]);
    assign slot_enable = e_tab[slot_sel];

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // Channel unit: ack after d_tab[slot] wait cycles; optionally junk acks while idle.
    always @(negedge clk) begin
        if (sample_req) begin
            if (ack_wait >= d_tab[slot_sel]) begin
                sample_ack  = 1'b1;
                sample_data = s_tab[slot_sel];
            end else begin
                sample_ack = 1'b0;
                ack_wait++;
            end
        end else begin
            ack_wait    = 0;
            sample_ack  = spur;
            sample_data = 8'h5A;
        end
    end

    function automatic int dac(input int a);
        int v;
        v = a >>> 2;
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return v + 2048;
    endfunction

    function automatic logic [23:0] model();
        int l, r, p;
        l = 0;
        r = 0;
        for (int i = 0; i < 12; i++) begin
            p = (TO_EN && d_tab[i] >= TO_CYC) ? 0 : int'(s_tab[i]) * v_tab[i];
            if (e_tab[i][0]) l += p;
            if (e_tab[i][1]) r += p;
        end
        return {12'(dac(l)), 12'(dac(r))};
    endfunction

    task automatic set_slots(input int smp, input int vol, input int en);
        for (int i = 0; i < 12; i++) begin
            s_tab[i] = byte'(smp);
            v_tab[i] = vol;
            e_tab[i] = 2'(en);
            d_tab[i] = 0;
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < max_cyc);
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        if (nreset && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = sb.pop_front();
                check("left_out", int'(left_out), int'(e[23:12]));
                check("right_out", int'(right_out), int'(e[11:0]));
            end
        end
    end

    initial begin
        int c, len;
        nreset    = 1'b0;
        clr_flags = 1'b0;
        spur      = 1'b0;
        ack_wait  = 0;
        sample_ack  = 1'b0;
        sample_data = 8'h00;
        set_slots(0, 0, 0);
        repeat (3) @(negedge clk);

        check("rst_left", int'(left_out), 'h800);
        check("rst_right", int'(right_out), 'h800);
        check("rst_req", int'(sample_req), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_slot", int'(slot_sel), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout", int'(timeout), 0);

        // Zero volume everywhere; release lands in cycle 0, first valid in cycle 56.
        for (int i = 0; i < 12; i++) s_tab[i] = byte'($urandom_range(0, 255));
        for (int i = 0; i < 12; i++) e_tab[i] = 2'd3;
        sb.push_back(model());
        sb.push_back(model());
        nreset = 1'b1;
        wait_valid(200, c);
        check("first_valid_cycle", c, 56);
        wait_valid(64, c);
        check("frame_period", c, 32);
        check("overrun_idle", int'(overrun), 0);

        // Single slot, left only, with junk acks while no request is open.
        set_slots(0, 0, 0);
        s_tab[0] = 8'sd100; v_tab[0] = 15; e_tab[0] = 2'b01;
        for (int i = 1; i < 12; i++) s_tab[i] = byte'($urandom_range(0, 255));
        sb.push_back(model());
        spur = 1'b1;
        wait_valid(64, c);
        check("frame_period_spur", c, 32);
        spur = 1'b0;

        set_slots(127, 15, 3);
        sb.push_back(model());
        wait_valid(64, c);
        set_slots(-128, 15, 3);
        sb.push_back(model());
        wait_valid(64, c);

        // Random mixes; at most 6 extra wait cycles so frames still fit.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 12; i++) begin
                s_tab[i] = byte'($urandom_range(0, 255));
                v_tab[i] = $urandom_range(0, 15);
                e_tab[i] = 2'($urandom_range(0, 3));
                d_tab[i] = 0;
            end
            d_tab[$urandom_range(0, 11)] = $urandom_range(0, 6);
            sb.push_back(model());
            wait_valid(80, c);
        end
        check("overrun_random", int'(overrun), 0);

        // Slow ack on slot 3 stretches the frame past the next tick.
        set_slots(-77, 9, 2);
        s_tab[3] = 8'sd120; e_tab[3] = 2'b11; e_tab[0] = 2'b01;
        d_tab[3] = 40;
        sb.push_back(model());
        wait_valid(200, c);
        check("overrun_set", int'(overrun), 1);
        set_slots(50, 8, 1);
        sb.push_back(model());
        wait_valid(120, c);
        check("overrun_sticky", int'(overrun), 1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("overrun_clr", int'(overrun), 0);
        check("left_before_rst", int'(left_out), 'hCB0);

        // Asynchronous reset in the middle of slot 5's request.
        c = 0;
        while (!(sample_req && slot_sel == 4'd5) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("reach_slot5", int'(sample_req && slot_sel == 4'd5), 1);
        #2 nreset = 1'b0;
        #1;
        check("arst_req", int'(sample_req), 0);
        check("arst_left", int'(left_out), 'h800);
        check("arst_right", int'(right_out), 'h800);
        check("arst_slot", int'(slot_sel), 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        sb.push_back(model());
        wait_valid(200, c);
        check("rst_valid_cycle", c, 56);

`ifdef WTS_MIX_TIMEOUT_EN
        // No ack on slot 2: request should be abandoned after 16 cycles.
        for (int i = 0; i < 12; i++) begin
            s_tab[i] = byte'($urandom_range(1, 100));
            v_tab[i] = $urandom_range(1, 15);
            e_tab[i] = 2'b11;
            d_tab[i] = 0;
        end
        d_tab[2] = 255;
        sb.push_back(model());
        c = 0;
        while (!(sample_req && slot_sel == 4'd2) && c < 100) begin
            @(negedge clk);
            c++;
        end
        len = 0;
        while (sample_req && slot_sel == 4'd2 && len < 100) begin
            @(negedge clk);
            len++;
        end
        check("timeout_req_len", len, TO_CYC);
        check("timeout_flag", int'(timeout), 1);
        wait_valid(100, c);
        d_tab[2] = 0;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        check("timeout_clr", int'(timeout), 0);
`else
        len = 0;
        check("timeout_tied", int'(timeout), len);
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
